pc_ctrl: RTL and testbench
==========================

Name: pc_ctrl

Overview:
- Next-PC controller sitting in front of the PC register block; drives that block's `jmp`/`dst` inputs and reads back its `val`.
- Arbitrates redirect requests from trap, trap-return and branch/jump sources, handles instruction-fetch backpressure and external halt, and holds the exception PC.
- A PC hold is a self-jump: `jmp=1` with `dst=pc`. The PC block therefore needs no extra enable.

Parameters:
- RST_VEC, 32'h0000_0000, boot address loaded on the first cycle after reset.
- TRAP_VEC, 32'h0000_0100, trap handler entry address.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc  in  32  current PC value (the PC block's `val`).
- br_req  in  1  branch/jump taken this cycle (execute stage).
- br_dst  in  32  branch/jump target.
- trap_req  in  1  exception/ecall raised this cycle.
- trap_pc  in  32  PC of the trapping instruction.
- ret_req  in  1  trap return (mret).
- imem_gnt  in  1  instruction memory accepted the fetch at `pc`.
- halt  in  1  level; freeze fetch while high.
- jmp  out  1  load `dst` into PC at next edge.
- dst  out  32  PC load value.
- imem_req  out  1  fetch request at `pc`.
- flush  out  1  kill the instruction currently in fetch/decode.
- epc  out  32  saved exception PC.
- halted  out  1  controller is in HALT.

Behaviour:
- **Reset (while rst=1):**
  - `jmp`=0, `dst`=0, `imem_req`=0, `flush`=0, `epc`=0, `halted`=0.
  - State goes to BOOT.
  - Reset asserted in any state aborts the state immediately; no pending redirect survives.
- **States:** BOOT, RUN, WAIT, HALT.
- **BOOT** (exactly 1 cycle):
  - `jmp`=1, `dst`=RST_VEC, `imem_req`=0.
  - Next state RUN; `flush`=1 in the following cycle.
- **RUN:** `imem_req`=1. Same-cycle redirect priority, highest first:
  1. trap_req: `jmp`=1, `dst`=TRAP_VEC; `epc`<=`trap_pc` at the edge.
  2. ret_req: `jmp`=1, `dst`=`epc` (value before any update this cycle).
  3. br_req: `jmp`=1, `dst`=`br_dst`.
  4. halt: `jmp`=1, `dst`=`pc`; next state HALT.
  5. imem_gnt=0: `jmp`=1, `dst`=`pc`; next state WAIT.
  6. Otherwise: `jmp`=0; the PC block increments.
- **Redirect details:**
  - `jmp`/`dst` are combinational from state and inputs; the new PC is visible on `pc` one edge later (1-cycle latency).
  - `flush` is registered: high for exactly the one cycle after any redirect (trap, ret, br, BOOT). It is not raised for a hold.
  - Lower-priority requests in a cycle where a higher one wins are dropped, not queued.
  - A redirect overrides `imem_gnt`=0: the outstanding fetch is abandoned and the state stays RUN.
  - halt together with a redirect: the redirect is taken this cycle and HALT is entered on the next cycle in which halt is still high.
- **WAIT:** `imem_req`=1; `jmp`=1, `dst`=`pc` (hold).
  - imem_gnt=1: release hold (`jmp`=0 that cycle), next state RUN.
  - Redirects follow the RUN priority and return to RUN.
  - halt: next state HALT.
- **HALT:** `imem_req`=0, `halted`=1, `jmp`=1, `dst`=`pc`.
  - halt low: next state RUN.
  - trap_req is honoured in HALT (`epc` captured, jump to TRAP_VEC, stay HALT while halt=1).
  - br_req and ret_req are ignored in HALT.
- **Width rules:** all addresses are 32 bits, no arithmetic in this block (increment stays in the PC block), no wrap handling required.
- **Back-to-back:** trap in cycle N followed by ret in cycle N+1 gives `dst`=new `epc` (= `trap_pc` from N).

Optional Feature:
- Macro PC_CTRL_ALIGN_CHK_EN.
- **Defined:**
  - A br_req with `br_dst[1:0]`!=0 is converted into a trap: `dst`=TRAP_VEC, `epc`<=`br_dst`.
  - Extra output `misalign` (1 bit, reset 0) pulses for one cycle, registered.
  - It ranks as trap priority; a real trap_req in the same cycle wins (`epc`=`trap_pc`).
- **Undefined:** `dst`=`{br_dst[31:2],2'b00}` for branches; no `misalign` port.

Test Plan:
- Reset 2 cycles, release, imem_gnt=1 -> cycle after release: `jmp`=1, `dst`=0x0; next cycle `flush`=1; `pc` then 0x0, 0x4, 0x8 with `jmp`=0.
- At `pc`=0x8 assert br_req with `br_dst`=0x40 for 1 cycle -> `jmp`=1, `dst`=0x40 same cycle; `pc`=0x40 next edge; `flush`=1 exactly that cycle.
- At `pc`=0x44 hold imem_gnt=0 for 3 cycles -> WAIT, `jmp`=1, `dst`=0x44 each cycle, `pc` stays 0x44, `flush`=0; regrant -> `pc` advances to 0x48.
- Same cycle trap_req (`trap_pc`=0x48), ret_req and br_req (`br_dst`=0x80) -> `dst`=0x100, `epc`=0x48; next cycle ret_req alone -> `dst`=0x48.
- halt high 4 cycles at `pc`=0x10 -> `halted`=1, `imem_req`=0, `pc` frozen at 0x10; br_req during HALT ignored; halt low -> RUN, `pc` continues 0x14.
- With PC_CTRL_ALIGN_CHK_EN, br_req with `br_dst`=0x42 -> `dst`=0x100, `epc`=0x42, `misalign`=1 for one cycle; without the macro -> `dst`=0x40.

Source files
------------

// File: rtl/pc_ctrl.sv
// pc_ctrl: next-PC controller in front of the PC register block.
//
// Purpose
//   Chooses what the PC block loads on the next edge. It arbitrates
//   redirects from trap, trap-return (mret) and branch/jump sources. It also
//   handles fetch backpressure (imem_gnt) and the external halt level, and
//   it holds the exception PC. A PC hold is a self-jump (jmp=1, dst=pc), so
//   the PC block needs no enable. When jmp=0 the PC block increments on its
//   own, and this block does no arithmetic.
//
// Configuration
//   PC_CTRL_ALIGN_CHK_EN : when defined, a branch to a target with
//     br_dst[1:0]!=0 becomes a trap. It goes to TRAP_VEC with epc<=br_dst and
//     pulses the extra output 'misalign'. When undefined, branch targets are
//     forced word-aligned and there is no 'misalign' port.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   pc        in   [31:0] current PC (PC block 'val')
//   br_req    in   branch/jump taken this cycle
//   br_dst    in   [31:0] branch/jump target
//   trap_req  in   exception/ecall this cycle
//   trap_pc   in   [31:0] PC of trapping instruction
//   ret_req   in   trap return
//   imem_gnt  in   fetch at 'pc' accepted
//   halt      in   level, freeze fetch while high
//   jmp       out  load dst into PC at next edge (combinational)
//   dst       out  [31:0] PC load value (combinational)
//   imem_req  out  fetch request at 'pc' (combinational)
//   flush     out  registered, high for the one cycle after a redirect
//   epc       out  [31:0] saved exception PC (registered)
//   halted    out  controller in HALT (combinational)
//   misalign  out  registered one-cycle pulse (only with PC_CTRL_ALIGN_CHK_EN)

module pc_ctrl #(
  parameter logic [31:0] RST_VEC  = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        br_req,
  input  logic [31:0] br_dst,
  input  logic        trap_req,
  input  logic [31:0] trap_pc,
  input  logic        ret_req,
  input  logic        imem_gnt,
  input  logic        halt,
  output logic        jmp,
  output logic [31:0] dst,
  output logic        imem_req,
  output logic        flush,
  output logic [31:0] epc,
`ifdef PC_CTRL_ALIGN_CHK_EN
  output logic        misalign,
`endif
  output logic        halted
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_WAIT, S_HALT} state_t;

  // Winning redirect among trap / misaligned branch / ret / branch.
  typedef struct packed {
    logic        take;
    logic [31:0] dst;
    logic        epc_we;
    logic [31:0] epc_d;
  } redir_t;

  state_t      state, state_nxt;
  redir_t      redir;
  logic        br_mis;
  logic        fire;     // a redirect (not a hold) is taken this cycle
  logic        epc_we;
  logic [31:0] epc_d;

`ifdef PC_CTRL_ALIGN_CHK_EN
  assign br_mis = br_req & (br_dst[1:0] != 2'b00);
`else
  // Low target bits are discarded when the alignment check is off.
  logic unused_br_lsb;
  assign br_mis        = 1'b0;
  assign unused_br_lsb = ^br_dst[1:0];
`endif

  // Redirect priority for RUN/WAIT. A misaligned branch ranks as a trap, so
  // it beats ret_req but loses to a real trap_req. Losers are dropped.
  always_comb begin
    redir = '0;
    if (trap_req) begin
      redir.take   = 1'b1;
      redir.dst    = TRAP_VEC;
      redir.epc_we = 1'b1;
      redir.epc_d  = trap_pc;
    end else if (br_mis) begin
      redir.take   = 1'b1;
      redir.dst    = TRAP_VEC;
      redir.epc_we = 1'b1;
      redir.epc_d  = br_dst;
    end else if (ret_req) begin
      redir.take = 1'b1;
      redir.dst  = epc;          // pre-update value
    end else if (br_req) begin
      redir.take = 1'b1;
      redir.dst  = {br_dst[31:2], 2'b00};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_BOOT;
    else     state <= state_nxt;
  end

  // Next-state logic. A redirect always lands in RUN. If halt is also high,
  // HALT is entered on a later cycle, once no redirect competes with it.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_BOOT: state_nxt = S_RUN;
      S_RUN: begin
        if      (redir.take) state_nxt = S_RUN;
        else if (halt)       state_nxt = S_HALT;
        else if (!imem_gnt)  state_nxt = S_WAIT;
        else                 state_nxt = S_RUN;
      end
      S_WAIT: begin
        if      (redir.take) state_nxt = S_RUN;
        else if (halt)       state_nxt = S_HALT;
        else if (imem_gnt)   state_nxt = S_RUN;
        else                 state_nxt = S_WAIT;
      end
      S_HALT: state_nxt = halt ? S_HALT : S_RUN;
      default: state_nxt = S_BOOT;
    endcase
  end

  // Output logic. Everything is forced idle while rst is high, so a redirect
  // decoded in the reset cycle never reaches the PC block or epc.
  always_comb begin
    jmp      = 1'b0;
    dst      = '0;
    imem_req = 1'b0;
    halted   = 1'b0;
    fire     = 1'b0;
    epc_we   = 1'b0;
    epc_d    = trap_pc;
    if (!rst) begin
      unique case (state)
        S_BOOT: begin
          jmp  = 1'b1;
          dst  = RST_VEC;
          fire = 1'b1;
        end
        S_RUN, S_WAIT: begin
          imem_req = 1'b1;
          dst      = pc;
          if (redir.take) begin
            // Redirect abandons any outstanding (ungranted) fetch.
            jmp    = 1'b1;
            dst    = redir.dst;
            fire   = 1'b1;
            epc_we = redir.epc_we;
            epc_d  = redir.epc_d;
          end else if (halt || !imem_gnt) begin
            jmp = 1'b1;              // hold: self-jump, no flush
          end
        end
        S_HALT: begin
          halted = 1'b1;
          jmp    = 1'b1;
          dst    = pc;
          // Only traps get through a halt; br/ret are ignored.
          if (trap_req) begin
            dst    = TRAP_VEC;
            fire   = 1'b1;
            epc_we = 1'b1;
            epc_d  = trap_pc;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      flush <= 1'b0;
      epc   <= '0;
    end else begin
      flush <= fire;
      if (epc_we) epc <= epc_d;
    end
  end

`ifdef PC_CTRL_ALIGN_CHK_EN
  // Pulse only when the misaligned branch actually won arbitration.
  logic mis_fire;
  assign mis_fire = !rst && (state == S_RUN || state == S_WAIT) &&
                    !trap_req && br_mis;

  always_ff @(posedge clk) begin
    if (rst) misalign <= 1'b0;
    else     misalign <= mis_fire;
  end
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl. It contains a behavioural PC register (load dst
// on jmp, else +4) so that the controller is exercised in closed loop.
// Inputs change 1 time unit after the rising edge, and outputs are sampled
// 1 time unit after that.

module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        br_req, trap_req, ret_req, imem_gnt, halt;
  logic [31:0] br_dst, trap_pc;
  logic        jmp, imem_req, flush, halted;
  logic [31:0] dst, epc;
`ifdef PC_CTRL_ALIGN_CHK_EN
  logic        misalign;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .pc       (pc),
    .br_req   (br_req),
    .br_dst   (br_dst),
    .trap_req (trap_req),
    .trap_pc  (trap_pc),
    .ret_req  (ret_req),
    .imem_gnt (imem_gnt),
    .halt     (halt),
    .jmp      (jmp),
    .dst      (dst),
    .imem_req (imem_req),
    .flush    (flush),
    .epc      (epc),
`ifdef PC_CTRL_ALIGN_CHK_EN
    .misalign (misalign),
`endif
    .halted   (halted)
  );

  // PC register block
  always @(posedge clk) begin
    if (rst)      pc <= 32'h0;
    else if (jmp) pc <= dst;
    else          pc <= pc + 32'h4;
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Advance to 1 unit after the next rising edge (input drive point).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Settle the combinational outputs after driving inputs.
  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; br_req = 1'b0; br_dst = '0; trap_req = 1'b0; trap_pc = '0;
    ret_req = 1'b0; imem_gnt = 1'b1; halt = 1'b0;

    // Reset
    cyc(); settle();
    chk("rst_jmp", jmp, 0);        chk("rst_dst", dst, 0);
    chk("rst_req", imem_req, 0);   chk("rst_flush", flush, 0);
    chk("rst_epc", epc, 0);        chk("rst_halted", halted, 0);
    cyc(); rst = 1'b0; settle();
    // BOOT
    chk("boot_jmp", jmp, 1); chk("boot_dst", dst, 32'h0); chk("boot_req", imem_req, 0);
    cyc(); settle();
    chk("run0_flush", flush, 1); chk("run0_pc", pc, 32'h0);
    chk("run0_jmp", jmp, 0);     chk("run0_req", imem_req, 1);
    cyc(); settle();
    chk("run1_pc", pc, 32'h4); chk("run1_flush", flush, 0); chk("run1_jmp", jmp, 0);
    cyc(); settle();
    chk("run2_pc", pc, 32'h8);

    // Branch to 0x40
    br_req = 1'b1; br_dst = 32'h40; settle();
    chk("br_jmp", jmp, 1); chk("br_dst", dst, 32'h40); chk("br_noflush", flush, 0);
    cyc(); br_req = 1'b0; settle();
    chk("br_pc", pc, 32'h40); chk("br_flush", flush, 1); chk("br_post_jmp", jmp, 0);
    cyc(); settle();
    chk("br_pc4", pc, 32'h44); chk("br_flush_off", flush, 0);

    // Fetch backpressure: 3 cycles without grant
    imem_gnt = 1'b0; settle();
    chk("w0_jmp", jmp, 1); chk("w0_dst", dst, 32'h44);
    cyc(); settle();
    chk("w1_pc", pc, 32'h44); chk("w1_jmp", jmp, 1); chk("w1_dst", dst, 32'h44);
    chk("w1_flush", flush, 0); chk("w1_req", imem_req, 1);
    cyc(); settle();
    chk("w2_pc", pc, 32'h44); chk("w2_dst", dst, 32'h44); chk("w2_flush", flush, 0);
    cyc(); imem_gnt = 1'b1; settle();
    chk("w3_pc", pc, 32'h44); chk("w3_release", jmp, 0); chk("w3_flush", flush, 0);
    cyc(); settle();
    chk("w4_pc", pc, 32'h48);

    // Trap + ret + branch in the same cycle: trap wins
    trap_req = 1'b1; trap_pc = 32'h48; ret_req = 1'b1; br_req = 1'b1; br_dst = 32'h80;
    settle();
    chk("tr_jmp", jmp, 1); chk("tr_dst", dst, 32'h100); chk("tr_epc_old", epc, 0);
    cyc(); trap_req = 1'b0; br_req = 1'b0; settle();
    // ret alone, back-to-back: uses freshly captured epc
    chk("tr_epc", epc, 32'h48); chk("tr_pc", pc, 32'h100); chk("tr_flush", flush, 1);
    chk("ret_jmp", jmp, 1);     chk("ret_dst", dst, 32'h48);
    cyc(); ret_req = 1'b0; settle();
    chk("ret_pc", pc, 32'h48); chk("ret_flush", flush, 1); chk("ret_post_jmp", jmp, 0);

    // Branch to 0x10, then halt for 4 cycles
    br_req = 1'b1; br_dst = 32'h10; settle();
    chk("br2_dst", dst, 32'h10);
    cyc(); br_req = 1'b0; halt = 1'b1; settle();
    chk("h0_pc", pc, 32'h10); chk("h0_jmp", jmp, 1); chk("h0_dst", dst, 32'h10);
    chk("h0_halted", halted, 0); chk("h0_flush", flush, 1);
    cyc(); br_req = 1'b1; br_dst = 32'h80; settle();
    chk("h1_halted", halted, 1); chk("h1_req", imem_req, 0); chk("h1_pc", pc, 32'h10);
    chk("h1_br_ign_dst", dst, 32'h10); chk("h1_flush", flush, 0);
    cyc(); br_req = 1'b0; settle();
    chk("h2_pc", pc, 32'h10); chk("h2_halted", halted, 1); chk("h2_br_noflush", flush, 0);
    cyc(); settle();
    chk("h3_pc", pc, 32'h10);
    cyc(); halt = 1'b0; settle();
    chk("h4_pc", pc, 32'h10); chk("h4_halted", halted, 1); chk("h4_dst", dst, 32'h10);
    cyc(); settle();
    chk("hr_halted", halted, 0); chk("hr_req", imem_req, 1);
    chk("hr_pc", pc, 32'h10);    chk("hr_jmp", jmp, 0);
    cyc(); settle();
    chk("hr_pc4", pc, 32'h14);

    // Trap honoured in HALT
    halt = 1'b1; settle();
    chk("ht0_dst", dst, 32'h14);
    cyc(); trap_req = 1'b1; trap_pc = 32'h24; settle();
    chk("ht1_halted", halted, 1); chk("ht1_jmp", jmp, 1); chk("ht1_dst", dst, 32'h100);
    cyc(); trap_req = 1'b0; halt = 1'b0; settle();
    chk("ht2_epc", epc, 32'h24); chk("ht2_pc", pc, 32'h100);
    chk("ht2_flush", flush, 1);  chk("ht2_halted", halted, 1);
    cyc(); settle();
    chk("ht3_pc", pc, 32'h100); chk("ht3_halted", halted, 0); chk("ht3_flush", flush, 0);

    // Misaligned branch target
    br_req = 1'b1; br_dst = 32'h42; settle();
`ifdef PC_CTRL_ALIGN_CHK_EN
    chk("mis_dst", dst, 32'h100);
    cyc(); br_req = 1'b0; settle();
    chk("mis_epc", epc, 32'h42); chk("mis_pulse", misalign, 1); chk("mis_flush", flush, 1);
    chk("mis_pc", pc, 32'h100);
    cyc(); settle();
    chk("mis_pulse_off", misalign, 0);
`else
    chk("mis_dst", dst, 32'h40);
    cyc(); br_req = 1'b0; settle();
    chk("mis_epc", epc, 32'h24); chk("mis_flush", flush, 1); chk("mis_pc", pc, 32'h40);
    cyc(); settle();
    chk("mis_pc4", pc, 32'h44);
`endif

    // Reset aborts a pending trap
    rst = 1'b1; trap_req = 1'b1; trap_pc = 32'h99; settle();
    chk("ra_jmp", jmp, 0); chk("ra_dst", dst, 0); chk("ra_req", imem_req, 0);
    cyc(); trap_req = 1'b0; rst = 1'b0; settle();
    chk("ra_epc", epc, 0); chk("ra_flush", flush, 0);
    chk("ra_boot_jmp", jmp, 1); chk("ra_boot_dst", dst, 32'h0);
    cyc(); settle();
    chk("ra_run_flush", flush, 1); chk("ra_run_pc", pc, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
